// File: rtl/errcap_pkg.sv
// errcap_pkg: shared entry type, read FSM states and constants for error_capture_fifo (ERRCAP_TIMESTAMP_EN adds a timestamp field)
package errcap_pkg;
  localparam logic [7:0]  COUNT_MAX    = 8'd255;
  localparam logic [15:0] OVF_MAX      = 16'hFFFF;
  localparam logic [31:0] ERRCAP_EMPTY = 32'hFF00_0000;
  typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_HOLD} rd_state_e;
  typedef struct packed {
    logic [7:0]  port;
    logic [7:0]  count;
    logic [15:0] bits;
`ifdef ERRCAP_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } errcap_entry_t;
endpackage

// File: rtl/errcap_fifo.sv
// errcap_fifo: synchronous register FIFO with wrap-bit pointers, flush, full/empty and occupancy
module errcap_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_push, do_pop;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_o = wp_q == rp_q;
  assign level_o = wp_q - rp_q;
  assign dout_o  = mem_q[rp_q[AW-1:0]];
  // pointer advance; flush wins over any push or pop
  always_comb begin
    do_push = push_i && !full_o && !clear_i;
    do_pop  = pop_i && !empty_o && !clear_i;
    wp_d    = clear_i ? '0 : wp_q + (AW+1)'(do_push);
    rp_d    = clear_i ? '0 : rp_q + (AW+1)'(do_pop);
  end
  // pointer registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/error_capture_fifo.sv
// error_capture_fifo: coalesces per-port error strobes, arbitrates them round-robin into a FIFO drained by a req/ack read port (ERRCAP_TIMESTAMP_EN adds rd_ts)
module error_capture_fifo import errcap_pkg::*; #(
  parameter int PORTS    = 5,
  parameter int ERRWIDTH = 16,
  parameter int DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PORTS-1:0]          err,
  input  logic [PORTS*ERRWIDTH-1:0] errbits,
  input  logic                      clear,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic [31:0]               rd_data,
`ifdef ERRCAP_TIMESTAMP_EN
  output logic [31:0]               rd_ts,
`endif
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               overflow
);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int EW = $bits(errcap_entry_t);
  logic [PORTS-1:0]    valid_q, valid_d;
  logic [ERRWIDTH-1:0] bits_q [PORTS];
  logic [ERRWIDTH-1:0] bits_d [PORTS];
  logic [7:0]          cnt_q [PORTS];
  logic [7:0]          cnt_d [PORTS];
  logic [15:0]         ovf_q, ovf_d;
  logic [3:0]          ovf_add;
  logic [16:0]         ovf_sum;
  logic [PW-1:0]       ptr_q, ptr_d, gnt_p;
  logic                gnt_hit, push, pop, load, full, empty;
  rd_state_e           state_q, state_d;
  logic [31:0]         rd_data_q, rd_data_d;
  errcap_entry_t       push_e, head_e;
`ifdef ERRCAP_TIMESTAMP_EN
  logic [31:0]         cyc_q, rd_ts_q, rd_ts_d;
  logic [31:0]         ts_q [PORTS];
  logic [31:0]         ts_d [PORTS];
  assign rd_ts = rd_ts_q;
`endif
  assign rd_ack   = state_q == RD_ACK;
  assign rd_data  = rd_data_q;
  assign overflow = ovf_q;
  // round-robin grant from ptr; uses the registered full flag so a popping-full FIFO is never pushed
  always_comb begin
    gnt_hit = 1'b0;
    gnt_p   = '0;
    for (int k = 0; k < PORTS; k++)
      if (!gnt_hit && valid_q[(int'(ptr_q) + k) % PORTS]) begin
        gnt_hit = 1'b1;
        gnt_p   = PW'((int'(ptr_q) + k) % PORTS);
      end
    push  = gnt_hit && !full && !clear;
    ptr_d = push ? ((int'(gnt_p) == PORTS - 1) ? '0 : gnt_p + 1'b1) : ptr_q;
  end
  // entry assembled from the granted latch
  always_comb begin
    push_e       = '0;
    push_e.port  = 8'(gnt_p);
    push_e.count = cnt_q[gnt_p];
    push_e.bits  = 16'(bits_q[gnt_p]);
`ifdef ERRCAP_TIMESTAMP_EN
    push_e.ts    = ts_q[gnt_p];
`endif
  end
  // pending latches: a granted port restarts from this cycle's strobe, others coalesce with saturation
  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    ovf_add = '0;
`ifdef ERRCAP_TIMESTAMP_EN
    ts_d    = ts_q;
`endif
    for (int p = 0; p < PORTS; p++)
      if (clear) begin
        valid_d[p] = 1'b0;
        bits_d[p]  = '0;
        cnt_d[p]   = '0;
      end else if ((push && int'(gnt_p) == p) || (err[p] && !valid_q[p])) begin
        valid_d[p] = err[p];
        bits_d[p]  = err[p] ? errbits[p*ERRWIDTH +: ERRWIDTH] : '0;
        cnt_d[p]   = {7'd0, err[p]};
`ifdef ERRCAP_TIMESTAMP_EN
        ts_d[p]    = cyc_q;
`endif
      end else if (err[p]) begin
        bits_d[p] = bits_q[p] | errbits[p*ERRWIDTH +: ERRWIDTH];
        cnt_d[p]  = (cnt_q[p] == COUNT_MAX) ? COUNT_MAX : cnt_q[p] + 8'd1;
        ovf_add   = ovf_add + 4'(cnt_q[p] == COUNT_MAX);
      end
    ovf_sum = {1'b0, ovf_q} + 17'(ovf_add);
    ovf_d   = clear ? '0 : ovf_sum[16] ? OVF_MAX : ovf_sum[15:0];
  end
  // latch, pointer and overflow registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= '0;
      for (int p = 0; p < PORTS; p++) begin
        bits_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  // read FSM next state: IDLE takes a request and loads data, ACK lasts one cycle, HOLD waits for release
  always_comb begin
    state_d   = clear ? RD_IDLE
              : (state_q == RD_IDLE) ? (rd_req ? RD_ACK : RD_IDLE)
              : (state_q == RD_ACK) ? RD_HOLD
              : (rd_req ? RD_HOLD : RD_IDLE);
    load      = !clear && state_q == RD_IDLE && rd_req;
    pop       = load && !empty;
    rd_data_d = load ? (empty ? ERRCAP_EMPTY : {head_e.port, head_e.count, head_e.bits}) : rd_data_q;
`ifdef ERRCAP_TIMESTAMP_EN
    rd_ts_d   = load ? (empty ? '0 : head_e.ts) : rd_ts_q;
`endif
  end
  // read FSM and read data registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= RD_IDLE;
      rd_data_q <= '0;
`ifdef ERRCAP_TIMESTAMP_EN
      rd_ts_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
`ifdef ERRCAP_TIMESTAMP_EN
      rd_ts_q   <= rd_ts_d;
`endif
    end
`ifdef ERRCAP_TIMESTAMP_EN
  // free-running cycle counter and timestamp latches
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cyc_q <= '0;
      for (int p = 0; p < PORTS; p++) ts_q[p] <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      ts_q  <= ts_d;
    end
`endif
  errcap_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_e),
    .dout_o  (head_e),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
endmodule

// File: tb/tb_error_capture_fifo.sv
// tb_error_capture_fifo: directed and random stimulus against a queue-based reference model of error_capture_fifo
module tb_error_capture_fifo;
  localparam int PORTS = 5;
  localparam int EW    = 16;
  localparam int DEPTH = 16;
  localparam logic [31:0] EMPTY_MARK = 32'hFF00_0000;
  logic                clk = 1'b0;
  logic                reset_n;
  logic [PORTS-1:0]    err_v;
  logic [PORTS*EW-1:0] errbits_v;
  logic                clear_v, rd_req_v, rd_ack;
  logic [31:0]         rd_data;
  logic [4:0]          level;
  logic [15:0]         overflow;
`ifdef ERRCAP_TIMESTAMP_EN
  logic [31:0]         rd_ts;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit          mv [PORTS];
  logic [15:0] mb [PORTS];
  int          mc [PORTS];
  int          mptr, movf, mstate;
  logic [31:0] mdata;
  logic [31:0] mq [$];
  always #5 clk = ~clk;
  error_capture_fifo #(.PORTS(PORTS), .ERRWIDTH(EW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .err      (err_v),
    .errbits  (errbits_v),
    .clear    (clear_v),
    .rd_req   (rd_req_v),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
`ifdef ERRCAP_TIMESTAMP_EN
    .rd_ts    (rd_ts),
`endif
    .level    (level),
    .overflow (overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    mq.delete();
    for (int p = 0; p < PORTS; p++) begin
      mv[p] = 0;
      mb[p] = '0;
      mc[p] = 0;
    end
    mptr = 0; movf = 0; mstate = 0; mdata = '0;
  endtask
  task automatic model_step();
    int g;
    bit full;
    logic [15:0] eb;
    if (clear_v) begin
      mq.delete();
      for (int p = 0; p < PORTS; p++) begin
        mv[p] = 0;
        mb[p] = '0;
        mc[p] = 0;
      end
      movf = 0; mstate = 0;
      return;
    end
    full = mq.size() == DEPTH;
    g = -1;
    if (!full)
      for (int k = 0; k < PORTS; k++)
        if (g < 0 && mv[(mptr + k) % PORTS]) g = (mptr + k) % PORTS;
    if (mstate == 0 && rd_req_v) begin
      mdata = (mq.size() > 0) ? mq.pop_front() : EMPTY_MARK;
      mstate = 1;
    end else if (mstate == 1) mstate = 2;
    else if (mstate == 2 && !rd_req_v) mstate = 0;
    if (g >= 0) begin
      mq.push_back({8'(g), 8'(mc[g]), mb[g]});
      mv[g] = 0;
      mptr = (g + 1) % PORTS;
    end
    for (int p = 0; p < PORTS; p++)
      if (err_v[p]) begin
        eb = errbits_v[p*EW +: EW];
        if (!mv[p]) begin
          mv[p] = 1; mb[p] = eb; mc[p] = 1;
        end else begin
          mb[p] = mb[p] | eb;
          if (mc[p] == 255) movf = (movf == 65535) ? 65535 : movf + 1;
          else mc[p]++;
        end
      end
  endtask
  task automatic step();
    model_step();
    @(negedge clk);
    chk("rd_ack", 32'(rd_ack), 32'(mstate == 1));
    chk("rd_data", rd_data, mdata);
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
  endtask
  task automatic pulse(input logic [PORTS-1:0] e, input logic [15:0] b, input int n);
    err_v = e;
    errbits_v = {PORTS{b}};
    repeat (n) step();
    err_v = '0;
  endtask
  task automatic rd(output logic [31:0] d);
    int n;
    rd_req_v = 1'b1;
    n = 0;
    step();
    while (!rd_ack && n < 4) begin
      step();
      n++;
    end
    chk("rd_ack_seen", 32'(rd_ack), 32'd1);
    d = rd_data;
    rd_req_v = 1'b0;
    step();
    step();
  endtask
  task automatic drain(output logic [31:0] last, output int cnt);
    logic [31:0] d;
    last = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rd(d);
      if (d == EMPTY_MARK) break;
      last = d;
      cnt++;
    end
  endtask
  initial begin
    logic [31:0] d, last;
    int cnt;
    logic [7:0] ord [5];
    reset_n = 1'b0; err_v = '0; errbits_v = '0; clear_v = 1'b0; rd_req_v = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(rd_ack), 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();
    pulse(5'b11111, 16'h00A5, 1);
    repeat (6) step();
    chk("simul_level", 32'(level), 32'd5);
    for (int k = 0; k < 5; k++) begin
      rd(d);
      chk("order_ptr0", 32'(d[31:24]), k);
      chk("order_ptr0_cnt", 32'(d[23:0]), 32'h01_00A5);
    end
    pulse(5'b00100, 16'h0041, 1);
    step(); step();
    rd(d);
    chk("single", d, 32'h0201_0041);
    chk("single_level", 32'(level), 32'd0);
    ord = '{8'd3, 8'd4, 8'd0, 8'd1, 8'd2};
    pulse(5'b11111, 16'h0003, 1);
    repeat (6) step();
    for (int k = 0; k < 5; k++) begin
      rd(d);
      chk("order_ptr3", 32'(d[31:24]), 32'(ord[k]));
    end
    rd(d);
    chk("empty_read", d, EMPTY_MARK);
    chk("empty_level", 32'(level), 32'd0);
    pulse(5'b00010, 16'h8000, 16);
    step();
    chk("fill_level", 32'(level), 32'd16);
    pulse(5'b00001, 16'h0001, 1);
    pulse(5'b00001, 16'h0002, 1);
    pulse(5'b00001, 16'h0004, 1);
    drain(last, cnt);
    chk("coalesce_last", last, 32'h0003_0007);
    chk("coalesce_cnt", 32'(cnt), 32'd17);
    pulse(5'b00100, 16'h1234, 16);
    step();
    chk("fill2_level", 32'(level), 32'd16);
    pulse(5'b00010, 16'h0001, 300);
    chk("sat_ovf", 32'(overflow), 32'd45);
    drain(last, cnt);
    chk("sat_last", last, 32'h01FF_0001);
    chk("sat_cnt", 32'(cnt), 32'd17);
    clear_v = 1'b1;
    step();
    clear_v = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);
    pulse(5'b01111, 16'h0F0F, 1);
    repeat (6) step();
    chk("pre_clear_level", 32'(level), 32'd4);
    rd_req_v = 1'b1;
    step();
    chk("in_ack", 32'(rd_ack), 32'd1);
    clear_v = 1'b1;
    step();
    clear_v = 1'b0;
    chk("clear_level", 32'(level), 32'd0);
    step();
    chk("post_clear_ack", 32'(rd_ack), 32'd1);
    chk("post_clear_data", rd_data, EMPTY_MARK);
    rd_req_v = 1'b0;
    step(); step();
    pulse(5'b10001, 16'h00FF, 1);
    repeat (4) step();
    rd_req_v = 1'b1;
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    mreset();
    rd_req_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      err_v = (i < 1500) ? PORTS'($urandom() & $urandom()) : PORTS'($urandom() & $urandom() & $urandom() & $urandom());
      for (int p = 0; p < PORTS; p++) errbits_v[p*EW +: EW] = 16'($urandom());
      rd_req_v = $urandom_range(0, 3) != 0;
      clear_v = $urandom_range(0, 299) == 0;
      step();
    end
    err_v = '0; clear_v = 1'b0; rd_req_v = 1'b0;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
